ram_hs: RTL and testbench



---
 rtl/ram_pkg.sv | 23 ++
 rtl/ram_hs_array.sv | 46 ++++
 rtl/ram_hs.sv | 141 ++++++++++++++
 tb/tb_ram_hs.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// ram_pkg: shared types and helpers for the ram_hs memory macro.
//   ram_state_e : controller state (clear sequence, normal operation)
//   ram_depth() : word count for a given address width
//   par_even()  : even parity of a data word, zero-extended to PAR_MAX_W
package ram_pkg;

   localparam int unsigned PAR_MAX_W = 64;

   typedef enum logic [0:0] {
      RAM_INIT = 1'b0,
      RAM_RUN  = 1'b1
   } ram_state_e;

   function automatic int unsigned ram_depth(input int unsigned addr_w);
      return 32'd1 << addr_w;
   endfunction

   // Callers zero-extend narrower words; zeros do not change parity.
   function automatic logic par_even(input logic [PAR_MAX_W-1:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/ram_hs_array.sv
// ram_hs_array: storage array for ram_hs, single address shared by one
// synchronous write port and one synchronous read port.
//   clk, rst_n : clock, async active-low reset (read register only)
//   we, wdata  : write enable / data, written on the rising edge
//   re         : read enable; rdata updates only when re is high
//   addr       : word address for both ports
//   rdata      : registered read word, holds between reads
module ram_hs_array
   import ram_pkg::*;
#(
   parameter int unsigned WORD_W = 8,
   parameter int unsigned ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] rdata
);

   localparam int unsigned DEPTH = ram_depth(ADDR_W);

   logic [WORD_W-1:0] mem_q [DEPTH];
   logic [WORD_W-1:0] rdata_q;

   // Storage has no reset; the controller clears it after reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[addr] <= wdata;
      end
   end

   // Read register holds its word until the next enabled read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
      end else if (re) begin
         rdata_q <= mem_q[addr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/ram_hs.sv
// ram_hs: single-port synchronous RAM with valid/ready request channel and
// registered read-response channel. Clears every word to zero after reset.
// Optional build macro RAM_PARITY_EN adds one even-parity bit per word.
//   clk, rst_n            : clock, async active-low reset
//   req_valid/req_ready   : request handshake (req_ready is combinational)
//   req_we, req_addr,
//   req_wdata             : request payload (1 = write)
//   inj_par_err           : store inverted parity on a write (parity build)
//   rsp_valid/rsp_ready   : response handshake
//   rsp_rdata, rsp_err    : read data and parity mismatch flag
//   init_done             : clear sequence finished
module ram_hs
   import ram_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic              inj_par_err,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              init_done
);

`ifdef RAM_PARITY_EN
   localparam int unsigned PAR_W = 1;
`else
   localparam int unsigned PAR_W = 0;
`endif
   localparam int unsigned WORD_W   = DATA_W + PAR_W;
   localparam int unsigned DEPTH    = ram_depth(ADDR_W);
   localparam logic [ADDR_W:0] PTR_LAST = (ADDR_W+1)'(DEPTH - 1);
   localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W+1)'(1);

   ram_state_e        state_q, state_d;
   logic [ADDR_W:0]   ptr_q, ptr_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              init_done_q, init_done_d;
   logic              req_fire;

   logic              arr_we, arr_re;
   logic [ADDR_W-1:0] arr_addr;
   logic [WORD_W-1:0] arr_wdata, arr_rdata;
   logic [WORD_W-1:0] wr_word;

   // Stored word for a RUN write, plus the response error derived from
   // the registered read word (parity of a zero word is zero, so '0 is a
   // correctly-parity'd clear value in both builds).
`ifdef RAM_PARITY_EN
   assign wr_word = {par_even(PAR_MAX_W'(req_wdata)) ^ inj_par_err, req_wdata};
   assign rsp_err = ^arr_rdata;
`else
   logic unused_inj;
   assign unused_inj = inj_par_err;
   assign wr_word    = req_wdata;
   assign rsp_err    = 1'b0;
`endif

   // State and handshake registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RAM_INIT;
         ptr_q       <= '0;
         rsp_valid_q <= 1'b0;
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         rsp_valid_q <= rsp_valid_d;
         init_done_q <= init_done_d;
      end
   end

   // Next state, handshake and array port mux (clear vs. request).
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      rsp_valid_d = rsp_valid_q;
      init_done_d = init_done_q;
      req_ready   = 1'b0;
      req_fire    = 1'b0;
      arr_we      = 1'b0;
      arr_re      = 1'b0;
      arr_addr    = req_addr;
      arr_wdata   = wr_word;

      case (state_q)
         RAM_INIT: begin
            arr_we    = 1'b1;
            arr_addr  = ptr_q[ADDR_W-1:0];
            arr_wdata = '0;
            ptr_d     = ptr_q + PTR_ONE;
            if (ptr_q == PTR_LAST) begin
               state_d = RAM_RUN;
            end
         end
         RAM_RUN: begin
            init_done_d = 1'b1;
            req_ready   = !rsp_valid_q || rsp_ready;
            req_fire    = req_valid && req_ready;
            arr_we      = req_fire && req_we;
            arr_re      = req_fire && !req_we;
            // A new read refills the slot; otherwise consumption empties it.
            if (arr_re) begin
               rsp_valid_d = 1'b1;
            end else if (rsp_ready) begin
               rsp_valid_d = 1'b0;
            end
         end
         default: begin
            state_d = RAM_INIT;
         end
      endcase
   end

   ram_hs_array #(
      .WORD_W (WORD_W),
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (arr_we),
      .re    (arr_re),
      .addr  (arr_addr),
      .wdata (arr_wdata),
      .rdata (arr_rdata)
   );

   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = arr_rdata[DATA_W-1:0];
   assign init_done = init_done_q;

endmodule

// File: tb/tb_ram_hs.sv
module tb_ram_hs;

   localparam int unsigned DW    = 8;
   localparam int unsigned AW    = 6;
   localparam int unsigned DEPTH = 64;
`ifdef RAM_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_valid, req_ready, req_we, inj_par_err;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          rsp_valid, rsp_ready, rsp_err, init_done;
   logic [DW-1:0] rsp_rdata;

   int errors = 0;
   int checks = 0;

   ram_hs #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_we      (req_we),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .inj_par_err (inj_par_err),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_rdata   (rsp_rdata),
      .rsp_err     (rsp_err),
      .init_done   (init_done)
   );

   always #5 clk = ~clk;

   // Behavioural model: edges since reset release decide the phase; a plain
   // array holds contents plus a per-word "parity corrupted" flag.
   int unsigned   m_edges;
   logic          m_rsp_valid;
   logic [DW-1:0] m_rdata;
   logic          m_err;
   logic [DW-1:0] m_mem  [DEPTH];
   logic          m_flip [DEPTH];
   logic          m_fire;

   function automatic logic m_ready();
      return (m_edges >= DEPTH) && (!m_rsp_valid || rsp_ready);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_edges     = 0;
         m_rsp_valid = 1'b0;
         m_rdata     = '0;
         m_err       = 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]  = '0;
            m_flip[i] = 1'b0;
         end
      end else begin
         m_fire = req_valid && m_ready();
         if (rsp_ready) m_rsp_valid = 1'b0;
         if (m_fire && req_we) begin
            m_mem[req_addr]  = req_wdata;
            m_flip[req_addr] = inj_par_err;
         end else if (m_fire) begin
            m_rsp_valid = 1'b1;
            m_rdata     = m_mem[req_addr];
            m_err       = PAR & m_flip[req_addr];
         end
         if (m_edges < 100000) m_edges++;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all();
      chk("req_ready", 32'(req_ready), 32'(m_ready()));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp_valid));
      chk("rsp_rdata", 32'(rsp_rdata), 32'(m_rdata));
      chk("rsp_err",   32'(rsp_err),   32'(m_err));
      chk("init_done", 32'(init_done), 32'(m_edges >= DEPTH + 1));
   endtask

   task automatic step();
      @(negedge clk);
      check_all();
   endtask

   task automatic idle();
      req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; inj_par_err = 1'b0;
   endtask

   task automatic req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic inj);
      req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; inj_par_err = inj;
   endtask

   // Release reset and measure the clear sequence from that point.
   task automatic release_and_init();
      int busy, first_done;
      busy = 0; first_done = -1;
      rst_n = 1'b1;
      for (int k = 0; k < 200; k++) begin
         if (!req_ready) busy++;
         if (init_done) begin first_done = k; break; end
         step();
      end
      chk("init_busy_cycles", 32'(busy), 32'd64);
      chk("init_done_edge",   32'(first_done), 32'd65);
   endtask

   task automatic assert_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_all();
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset_req_ready", 32'(req_ready), 32'd0);
   endtask

   initial begin
      int hs, vcount;
      logic [DW-1:0] held;

      idle();
      rsp_ready = 1'b1;
      rst_n = 1'b0;
      #1;
      check_all();
      chk("reset_rdata",     32'(rsp_rdata), 32'd0);
      chk("reset_init_done", 32'(init_done), 32'd0);
      @(negedge clk);
      req(1'b0, 6'h3F, '0, 1'b0);   // request held during INIT must be ignored
      release_and_init();
      idle();

      // Cleared words read back as zero.
      req(1'b0, 6'h00, '0, 1'b0); step();
      chk("clr_0x00", 32'(rsp_rdata), 32'd0);
      req(1'b0, 6'h1F, '0, 1'b0); step();
      chk("clr_0x1F", 32'(rsp_rdata), 32'd0);
      req(1'b0, 6'h3F, '0, 1'b0); step();
      chk("clr_0x3F", 32'(rsp_rdata), 32'd0);
      chk("clr_err",  32'(rsp_err),   32'd0);
      idle(); step();

      // Write then read on the next cycle.
      req(1'b1, 6'h10, 8'hA5, 1'b0); step();
      req(1'b0, 6'h10, '0, 1'b0); step();
      chk("wr_rd_valid", 32'(rsp_valid), 32'd1);
      chk("wr_rd_data",  32'(rsp_rdata), 32'hA5);
      idle(); step();

      // Parity corruption hook.
      req(1'b1, 6'h05, 8'h3C, 1'b1); step();
      req(1'b0, 6'h05, '0, 1'b0); step();
      chk("par_data", 32'(rsp_rdata), 32'h3C);
      chk("par_err",  32'(rsp_err),   32'(PAR));
      idle(); step();

      // Stall: response held for 3 cycles, exactly one handshake after.
      rsp_ready = 1'b0;
      req(1'b0, 6'h10, '0, 1'b0); step();
      held = rsp_rdata;
      chk("stall_first", 32'(held), 32'hA5);
      req(1'b0, 6'h05, '0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_ready", 32'(req_ready), 32'd0);
         chk("stall_data",  32'(rsp_rdata), 32'(held));
      end
      idle();
      rsp_ready = 1'b1;
      hs = 0;
      for (int i = 0; i < 4; i++) begin
         if (rsp_valid && rsp_ready) hs++;
         step();
      end
      chk("stall_handshakes", 32'(hs), 32'd1);

      // Back-to-back reads of a known pattern.
      for (int i = 0; i < 16; i++) begin
         req(1'b1, AW'(32 + i), DW'(i * 7 + 3), 1'b0); step();
      end
      vcount = 0;
      for (int i = 0; i < 16; i++) begin
         req(1'b0, AW'(32 + i), '0, 1'b0);
         chk("b2b_ready", 32'(req_ready), 32'd1);
         step();
         if (rsp_valid) vcount++;
         chk("b2b_data", 32'(rsp_rdata), 32'(DW'(i * 7 + 3)));
      end
      chk("b2b_valid_count", 32'(vcount), 32'd16);
      idle(); step();

      // Randomized traffic against the model.
      for (int i = 0; i < 1500; i++) begin
         req_valid   = ($urandom_range(0, 3) != 0);
         req_we      = $urandom_range(0, 1) == 1;
         req_addr    = AW'($urandom);
         req_wdata   = DW'($urandom);
         inj_par_err = ($urandom_range(0, 3) == 0);
         rsp_ready   = ($urandom_range(0, 2) != 0);
         step();
      end

      // Reset with a pending response, then reset again mid-clear.
      rsp_ready = 1'b0;
      req(1'b0, 6'h05, '0, 1'b0); step();
      assert_reset();
      rsp_ready = 1'b1;
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) step();
      assert_reset();
      step();
      release_and_init();
      idle();
      req(1'b0, 6'h10, '0, 1'b0); step();
      chk("post_reset_clr", 32'(rsp_rdata), 32'd0);
      req(1'b0, 6'h05, '0, 1'b0); step();
      chk("post_reset_err", 32'(rsp_err), 32'd0);
      idle(); step(); step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
